// File: rtl/counter_window_arbiter_pkg.sv
// Shared definitions for the counter window arbiter.
//   state_e  : window FSM states (IDLE -> CLEAR -> RUN -> REPORT -> IDLE)
//   wrap_inc : increment with wrap at n, used for the round-robin pointer
package cwa_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } state_e;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/counter_window_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first set request at or after ptr_i, wrapping past the top.
// Ports:
//   req_i   [NREQ-1:0] request vector
//   ptr_i   [IW-1:0]   highest-priority index this round
//   gnt_o   [NREQ-1:0] one-hot grant, zero when no request
//   idx_o   [IW-1:0]   index of the granted request (0 when none)
//   valid_o            at least one request present
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IW'((int'(ptr_i) + off) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/counter_window_arbiter.sv
// Shares one external up-counter between NREQ requesters. The winner of a
// round-robin pick gets the counter cleared, enabled for len cycles, and its
// captured count returned with a one-cycle done pulse.
// Handshake: req[i] is a level request that must stay high until done for
// that id; dropping it while its window runs cuts the window short (aborted).
// Ports:
//   clk, reset (sync, active-high)
//   req        [NREQ-1:0]       level requests
//   len        [NREQ*LEN_W-1:0] window lengths, slice i = len[i*LEN_W +: LEN_W]
//   grant      [NREQ-1:0]       one-hot current owner, 0 when idle
//   cnt_clear, cnt_enable       drives to the shared counter
//   cnt_value  [WIDTH-1:0]      shared counter output
//   done, done_id, aborted, result   completion report (valid with done)
//   state_dbg  [1:0]            current FSM state
module counter_window_arbiter
  import cwa_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LEN_W = 8,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic                  cnt_clear,
  output logic                  cnt_enable,
  input  logic [WIDTH-1:0]      cnt_value,
  output logic                  done,
  output logic [IW-1:0]         done_id,
  output logic                  aborted,
  output logic [WIDTH-1:0]      result,
  output logic [1:0]            state_dbg
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic [IW-1:0]     done_id_q, done_id_d;
  logic              aborted_q, aborted_d;
  logic [WIDTH-1:0]  result_q, result_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_valid;
  logic [LEN_W-1:0]  len_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_len
    assign len_arr[g] = len[g*LEN_W +: LEN_W];
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    aborted_d   = aborted_q;
    result_d    = result_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d     = arb_gnt;
          owner_d     = arb_idx;
          remaining_d = len_arr[arb_idx];
          abort_d     = 1'b0;
          state_d     = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (remaining_q == '0) ? REPORT : RUN;
      end
      RUN: begin
        // Enable stays high through the cycle in which the owner's request
        // drops; the window ends at the following edge.
        remaining_d = remaining_q - LEN_W'(1);
        if (remaining_q == LEN_W'(1)) begin
          state_d = REPORT;
        end else if (!req[owner_q]) begin
          abort_d = 1'b1;
          state_d = REPORT;
        end
      end
      REPORT: begin
        // Counter is idle here, so cnt_value is the final window count.
        done_d    = 1'b1;
        done_id_d = owner_q;
        aborted_d = abort_q;
        result_d  = cnt_value;
        grant_d   = '0;
        ptr_d     = IW'(wrap_inc(int'(owner_q), NREQ));
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      remaining_q <= '0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      aborted_q   <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      aborted_q   <= aborted_d;
      result_q    <= result_d;
    end
  end

  assign grant      = grant_q;
  assign cnt_clear  = (state_q == CLEAR);
  assign cnt_enable = (state_q == RUN);
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign aborted    = aborted_q;
  assign result     = result_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_counter_window_arbiter.sv
module tb_counter_window_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LEN_W = 9;
  localparam int IW    = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] len;
  logic [NREQ-1:0]       grant;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic [WIDTH-1:0]      cnt_value;
  logic                  done;
  logic [IW-1:0]         done_id;
  logic                  aborted;
  logic [WIDTH-1:0]      result;
  logic [1:0]            state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int n_clear  = 0;
  int n_en     = 0;
  logic [31:0] exp_q[$];

  counter_window_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .len        (len),
    .grant      (grant),
    .cnt_clear  (cnt_clear),
    .cnt_enable (cnt_enable),
    .cnt_value  (cnt_value),
    .done       (done),
    .done_id    (done_id),
    .aborted    (aborted),
    .result     (result),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset / shared counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset)           cnt_value <= '0;
    else if (cnt_clear)  cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_value + 8'd1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (cnt_clear)  n_clear++;
      if (cnt_enable) n_en++;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_len(input int i, input int v);
    len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    req   = '0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    n_clear = 0;
    n_en    = 0;
  endtask

  // Waits (bounded) for done, sampling on negedges. lat = negedges from call
  // to done; g1 = grant on the first negedge.
  task automatic wait_done(input string tag, input int budget, output int lat,
                           output logic [NREQ-1:0] g1, output logic [IW-1:0] id,
                           output logic ab, output logic [WIDTH-1:0] res);
    logic seen;
    seen = 1'b0;
    lat = -1; g1 = '0; id = '0; ab = 1'b0; res = '0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) g1 = grant;
      if (done) begin
        seen = 1'b1;
        lat  = k;
        id   = done_id;
        ab   = aborted;
        res  = result;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int lat;
    logic [NREQ-1:0] g1;
    logic [IW-1:0] id;
    logic ab;
    logic [WIDTH-1:0] res;
    int en_seen;

    len = '0;
    do_reset(3);
    reset = 1'b1;
    @(negedge clk);
    check("rst_grant",   32'(grant), 32'd0);
    check("rst_clear",   32'(cnt_clear), 32'd0);
    check("rst_enable",  32'(cnt_enable), 32'd0);
    check("rst_done",    32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    check("rst_result",  32'(result), 32'd0);
    check("rst_state",   32'(state_dbg), 32'd0);
    reset = 1'b0;
    n_clear = 0; n_en = 0;

    // 1: single request, len 5
    set_len(0, 5);
    req = 4'b0001;
    wait_done("t1", 40, lat, g1, id, ab, res);
    req = '0;
    check("t1_grant",   32'(g1), 32'b0001);
    check("t1_latency", 32'(lat), 32'd8);
    check("t1_result",  32'(res), 32'd5);
    check("t1_id",      32'(id), 32'd0);
    check("t1_aborted", 32'(ab), 32'd0);
    check("t1_clears",  32'(n_clear), 32'd1);
    check("t1_enables", 32'(n_en), 32'd5);
    check("t1_grant_after", 32'(grant), 32'd0);

    // 2: all four request, len 3 each, held for five windows
    do_reset(2);
    for (int i = 0; i < NREQ; i++) set_len(i, 3);
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      wait_done("t2", 40, lat, g1, id, ab, res);
      if (w == 4) req = '0;
      check("t2_order",  32'(id), exp_q.pop_front());
      check("t2_result", 32'(res), 32'd3);
    end
    check("t2_enables", 32'(n_en), 32'd15);
    check("t2_clears",  32'(n_clear), 32'd5);

    // 3: zero-length window on req[2] (pointer is 1 here)
    repeat (2) @(negedge clk);
    n_clear = 0; n_en = 0;
    set_len(2, 0);
    req = 4'b0100;
    wait_done("t3", 20, lat, g1, id, ab, res);
    req = '0;
    check("t3_grant",   32'(g1), 32'b0100);
    check("t3_latency", 32'(lat), 32'd3);
    check("t3_result",  32'(res), 32'd0);
    check("t3_id",      32'(id), 32'd2);
    check("t3_clears",  32'(n_clear), 32'd1);
    check("t3_enables", 32'(n_en), 32'd0);

    // 4: abort req[1] after four enables -> exactly five counted
    repeat (2) @(negedge clk);
    n_clear = 0; n_en = 0;
    set_len(1, 10);
    req = 4'b0010;
    en_seen = 0;
    for (int k = 0; k < 40 && en_seen < 4; k++) begin
      @(negedge clk);
      if (cnt_enable) en_seen++;
    end
    check("t4_four_enables", 32'(en_seen), 32'd4);
    @(posedge clk);
    #1 req = '0;
    wait_done("t4", 20, lat, g1, id, ab, res);
    check("t4_aborted", 32'(ab), 32'd1);
    check("t4_result",  32'(res), 32'd5);
    check("t4_id",      32'(id), 32'd1);
    repeat (5) @(negedge clk);
    check("t4_enables", 32'(n_en), 32'd5);

    // 5: reset in the middle of a 20-cycle window at count 7
    set_len(2, 20);
    req = 4'b0100;
    for (int k = 0; k < 40 && cnt_value != 8'd7; k++) @(negedge clk);
    check("t5_reached7", 32'(cnt_value), 32'd7);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    check("t5_grant",  32'(grant), 32'd0);
    check("t5_enable", 32'(cnt_enable), 32'd0);
    check("t5_clear",  32'(cnt_clear), 32'd0);
    check("t5_state",  32'(state_dbg), 32'd0);
    reset = 1'b0;
    en_seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) en_seen++;
    end
    check("t5_no_done", 32'(en_seen), 32'd0);
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    req = 4'b1011;
    wait_done("t5", 20, lat, g1, id, ab, res);
    req = '0;
    check("t5_ptr0_grant", 32'(g1), 32'b0001);
    check("t5_id",         32'(id), 32'd0);
    check("t5_result",     32'(res), 32'd2);

    // 6: 300-cycle window wraps the 8-bit counter to 44
    repeat (2) @(negedge clk);
    n_en = 0;
    set_len(1, 300);
    req = 4'b0010;
    wait_done("t6", 400, lat, g1, id, ab, res);
    req = '0;
    check("t6_result",  32'(res), 32'd44);
    check("t6_latency", 32'(lat), 32'd303);
    check("t6_enables", 32'(n_en), 32'd300);
    check("t6_aborted", 32'(ab), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
